// File: rtl/crc_stream_core.sv
// crc_stream_core
//   Streaming CRC engine with runtime-programmable polynomial, width (8..32),
//   init value, final XOR and input/output reflection. Words of 1..4 bytes are
//   accepted on a valid/ready stream, buffered in a small FIFO and folded into
//   the running CRC one byte per cycle. Messages may span any number of words;
//   the word flagged last produces a result that is held until accepted.
//
// Ports
//   pclk, preset                 clock, asynchronous active-high reset
//   clr_i                        synchronous abort: flush FIFO, load config, crc=init
//   cfg_poly_i / cfg_width_i     polynomial (implicit top bit omitted), width-1
//   cfg_init_i / cfg_xorv_i      initial value, final XOR value
//   cfg_revin_i / cfg_revout_i   reflect input bytes / reflect result
//   s_valid_i, s_ready_o         input word handshake
//   s_data_i, s_bytes_i, s_last_i  word data (lane 0 first), bytes-1, end of message
//   res_valid_o, res_ready_i     result handshake
//   res_data_o                   final CRC, zero-extended above the width
//   busy_o                       engine active or FIFO non-empty
//   fifo_cnt_o                   FIFO occupancy
module crc_stream_core #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             pclk,
    input  logic             preset,
    input  logic             clr_i,
    input  logic [31:0]      cfg_poly_i,
    input  logic [4:0]       cfg_width_i,
    input  logic [31:0]      cfg_init_i,
    input  logic [31:0]      cfg_xorv_i,
    input  logic             cfg_revin_i,
    input  logic             cfg_revout_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    input  logic [31:0]      s_data_i,
    input  logic [1:0]       s_bytes_i,
    input  logic             s_last_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [31:0]      res_data_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] fifo_cnt_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  bytes;
        logic        last;
    } word_t;

    // Widths below 8 bits are not supported; they are treated as 8.
    function automatic logic [4:0] eff_wm1(input logic [4:0] width_m1);
        return (width_m1 < 5'd7) ? 5'd7 : width_m1;
    endfunction

    function automatic logic [31:0] width_mask(input logic [4:0] width_m1);
        return 32'hFFFF_FFFF >> (5'd31 - eff_wm1(width_m1));
    endfunction

    // Bit-serial fold of one byte into a w-bit CRC held right-aligned.
    function automatic logic [31:0] fold_byte(input logic [31:0] crc,
                                              input logic [7:0]  din,
                                              input logic [31:0] poly,
                                              input logic [4:0]  width_m1,
                                              input logic        revin);
        logic [31:0] c;
        logic [31:0] mask;
        logic [4:0]  wm1;
        logic        fb;
        // NOTE: blocking assignments inside a function model the chained
        // per-bit logic; they become a combinational cascade, not registers.
        c    = crc;
        mask = width_mask(width_m1);
        wm1  = eff_wm1(width_m1);
        for (int i = 0; i < 8; i++) begin
            fb = c[wm1] ^ (revin ? din[i] : din[7-i]);
            c  = (c << 1) & mask;
            if (fb) c = c ^ (poly & mask);
        end
        return c;
    endfunction

    function automatic logic [31:0] finalize(input logic [31:0] crc,
                                             input logic [31:0] xorv,
                                             input logic [4:0]  width_m1,
                                             input logic        revout);
        logic [31:0] rev;
        logic [31:0] r;
        for (int i = 0; i < 32; i++) rev[i] = crc[31-i];
        // Full 32-bit reversal, then shift the w reflected bits back down.
        r = revout ? (rev >> (5'd31 - eff_wm1(width_m1))) : crc;
        return (r ^ xorv) & width_mask(width_m1);
    endfunction

    // ---------------------------------------------------------------- FIFO
    word_t            mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             fifo_full, fifo_empty, push, pop;

    assign fifo_full  = (cnt == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (cnt == '0);
    assign push       = s_valid_i && !fifo_full && !clr_i;
    assign s_ready_o  = !fifo_full;
    assign fifo_cnt_o = cnt;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clr_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // NOTE: the storage array has no reset; occupancy is tracked by the
    // pointers/count, so stale entries are never read.
    always_ff @(posedge pclk) begin
        if (push) mem[wr_ptr] <= '{data: s_data_i, bytes: s_bytes_i, last: s_last_i};
    end

    // ---------------------------------------------------------------- FSM
    state_t      state, state_nxt;
    logic        fold, finish, hs;
    word_t       word;
    logic [1:0]  byte_cnt;
    logic [31:0] crc, crc_folded;

    logic [31:0] sh_poly, sh_init, sh_xorv;
    logic [4:0]  sh_width;
    logic        sh_revin, sh_revout;

    assign crc_folded = fold_byte(crc, word.data[8*byte_cnt +: 8], sh_poly, sh_width, sh_revin);

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path
        // leaves a value unassigned and no latch is inferred.
        state_nxt = state;
        pop       = 1'b0;
        fold      = 1'b0;
        finish    = 1'b0;
        hs        = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                fold = 1'b1;
                if (byte_cnt == word.bytes) begin
                    if (word.last) begin
                        finish    = 1'b1;
                        state_nxt = DONE;
                    end else if (!fifo_empty) begin
                        pop = 1'b1;         // back-to-back: next word, no bubble
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DONE: begin
                if (res_ready_i) begin
                    hs        = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Abort wins over any pop or result handshake in the same cycle.
        if (clr_i) begin
            state_nxt = IDLE;
            pop       = 1'b0;
            hs        = 1'b0;
        end
    end

    assign res_valid_o = (state == DONE);
    assign busy_o      = (state != IDLE) || !fifo_empty;

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            sh_poly    <= '0;
            sh_width   <= '0;
            sh_init    <= '0;
            sh_xorv    <= '0;
            sh_revin   <= 1'b0;
            sh_revout  <= 1'b0;
            crc        <= '0;
            res_data_o <= '0;
            word       <= '0;
            byte_cnt   <= '0;
        end else if (clr_i || hs) begin
            // Shadow config is refreshed only at message boundaries.
            sh_poly   <= cfg_poly_i;
            sh_width  <= cfg_width_i;
            sh_init   <= cfg_init_i;
            sh_xorv   <= cfg_xorv_i;
            sh_revin  <= cfg_revin_i;
            sh_revout <= cfg_revout_i;
            crc       <= cfg_init_i & width_mask(cfg_width_i);
            byte_cnt  <= '0;
        end else begin
            if (fold) begin
                crc      <= crc_folded;
                byte_cnt <= byte_cnt + 2'd1;
            end
            if (finish) res_data_o <= finalize(crc_folded, sh_xorv, sh_width, sh_revout);
            if (pop) begin
                word     <= mem[rd_ptr];
                byte_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_crc_stream_core.sv
// Self-checking bench for crc_stream_core: known check values of several CRC
// standards, result backpressure with a full FIFO, clr_i aborts and a reset
// in the middle of a message. Expected results are queued when a message's
// last word is pushed and compared when the DUT hands the result over.
module tb_crc_stream_core;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int LIMIT = 300;

    logic          pclk = 1'b0;
    logic          preset;
    logic          clr_i;
    logic [31:0]   cfg_poly_i, cfg_init_i, cfg_xorv_i;
    logic [4:0]    cfg_width_i;
    logic          cfg_revin_i, cfg_revout_i;
    logic          s_valid_i, s_ready_o, s_last_i;
    logic [31:0]   s_data_i;
    logic [1:0]    s_bytes_i;
    logic          res_valid_o, res_ready_i;
    logic [31:0]   res_data_o;
    logic          busy_o;
    logic [CW-1:0] fifo_cnt_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb[$];

    always #5 pclk = ~pclk;

    crc_stream_core #(.FIFO_DEPTH(DEPTH)) dut (
        .pclk(pclk), .preset(preset), .clr_i(clr_i),
        .cfg_poly_i(cfg_poly_i), .cfg_width_i(cfg_width_i),
        .cfg_init_i(cfg_init_i), .cfg_xorv_i(cfg_xorv_i),
        .cfg_revin_i(cfg_revin_i), .cfg_revout_i(cfg_revout_i),
        .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
        .s_bytes_i(s_bytes_i), .s_last_i(s_last_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .res_data_o(res_data_o), .busy_o(busy_o), .fifo_cnt_o(fifo_cnt_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Result monitor: a handshake completes at the next rising edge.
    always @(negedge pclk) begin
        if (!preset && res_valid_o && res_ready_i) begin
            if (sb.size() == 0) check("unexpected_result", 32'(res_valid_o), 32'd0);
            else                check("result", res_data_o, sb.pop_front());
        end
    end

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic set_cfg(input logic [31:0] poly, input logic [4:0] wm1,
                           input logic [31:0] init, input logic [31:0] xorv,
                           input logic revin, input logic revout);
        cfg_poly_i   = poly;
        cfg_width_i  = wm1;
        cfg_init_i   = init;
        cfg_xorv_i   = xorv;
        cfg_revin_i  = revin;
        cfg_revout_i = revout;
    endtask

    task automatic do_clr();
        clr_i = 1'b1;
        @(posedge pclk); #1;
        clr_i = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] data, input logic [1:0] nb,
                             input logic last, input logic [31:0] exp);
        int n;
        s_valid_i = 1'b1;
        s_data_i  = data;
        s_bytes_i = nb;
        s_last_i  = last;
        n = 0;
        @(negedge pclk);
        while (!s_ready_o && n < LIMIT) begin
            @(negedge pclk);
            n++;
        end
        if (n >= LIMIT) check("push_timeout", 32'(n), 32'd0);
        @(posedge pclk); #1;
        s_valid_i = 1'b0;
        if (last) sb.push_back(exp);
    endtask

    // "123456789" as three words
    task automatic run_msg(input logic [31:0] exp);
        push_word(32'h3433_3231, 2'd3, 1'b0, 32'h0);
        push_word(32'h3837_3635, 2'd3, 1'b0, 32'h0);
        push_word(32'h0000_0039, 2'd0, 1'b1, exp);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < LIMIT) begin
            @(negedge pclk);
            n++;
        end
        if (n >= LIMIT) check("drain_timeout", 32'(sb.size()), 32'd0);
        repeat (2) @(posedge pclk);
        #1;
    endtask

    initial begin
        logic [31:0] held;
        int unstable;

        preset = 1'b1; clr_i = 1'b0; res_ready_i = 1'b1;
        s_valid_i = 1'b0; s_data_i = '0; s_bytes_i = '0; s_last_i = 1'b0;
        set_cfg(32'h0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
        repeat (3) @(posedge pclk);
        #1 preset = 1'b0;

        // Reset state
        @(negedge pclk);
        check("rst_res_valid", 32'(res_valid_o), 32'd0);
        check("rst_res_data",  res_data_o,       32'd0);
        check("rst_s_ready",   32'(s_ready_o),   32'd1);
        check("rst_busy",      32'(busy_o),      32'd0);
        check("rst_fifo_cnt",  32'(fifo_cnt_o),  32'd0);
        @(posedge pclk); #1;

        // Standard check values over "123456789"
        set_cfg(32'h04C1_1DB7, 5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
        do_clr(); run_msg(32'hCBF4_3926); drain();
        set_cfg(32'h0000_1021, 5'd15, 32'h0000_FFFF, 32'h0, 1'b0, 1'b0);
        do_clr(); run_msg(32'h0000_29B1); drain();
        set_cfg(32'h0000_8005, 5'd15, 32'h0, 32'h0, 1'b1, 1'b1);
        do_clr(); run_msg(32'h0000_BB3D); drain();
        set_cfg(32'h0000_0007, 5'd7, 32'h0, 32'h0, 1'b0, 1'b0);
        do_clr(); run_msg(32'h0000_00F4); drain();
        set_cfg(32'h0086_4CFB, 5'd23, 32'h00B7_04CE, 32'h0, 1'b0, 1'b0);
        do_clr(); run_msg(32'h0021_CF02); drain();

        // Result backpressure while the FIFO fills
        set_cfg(32'h04C1_1DB7, 5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
        do_clr();
        res_ready_i = 1'b0;
        run_msg(32'hCBF4_3926);
        push_word(32'h0063_6261, 2'd2, 1'b1, 32'h3524_41C2);   // "abc"
        run_msg(32'hCBF4_3926);
        repeat (5) @(negedge pclk);
        held = res_data_o;
        unstable = 0;
        repeat (20) begin
            @(negedge pclk);
            if (res_data_o !== held) unstable++;
        end
        check("bp_data_stable", 32'(unstable),    32'd0);
        check("bp_res_valid",   32'(res_valid_o), 32'd1);
        check("bp_res_data",    res_data_o,       32'hCBF4_3926);
        check("bp_fifo_full",   32'(fifo_cnt_o),  32'(DEPTH));
        check("bp_s_ready",     32'(s_ready_o),   32'd0);
        @(posedge pclk); #1;
        res_ready_i = 1'b1;
        push_word(32'h0000_0061, 2'd0, 1'b1, 32'hE8B7_BE43);   // "a"
        drain();

        // clr_i in the middle of a message
        push_word(32'h3433_3231, 2'd3, 1'b0, 32'h0);
        repeat (2) @(posedge pclk);
        #1;
        do_clr();
        @(negedge pclk);
        check("clr_busy",     32'(busy_o),     32'd0);
        check("clr_fifo_cnt", 32'(fifo_cnt_o), 32'd0);
        @(posedge pclk); #1;
        run_msg(32'hCBF4_3926);
        drain();

        // clr_i coincident with a push: the word is dropped
        s_valid_i = 1'b1; s_data_i = 32'h0000_0031; s_bytes_i = 2'd0; s_last_i = 1'b1;
        clr_i = 1'b1;
        @(posedge pclk); #1;
        s_valid_i = 1'b0; clr_i = 1'b0;
        @(negedge pclk);
        check("clrpush_fifo_cnt",  32'(fifo_cnt_o),  32'd0);
        check("clrpush_busy",      32'(busy_o),      32'd0);
        check("clrpush_res_valid", 32'(res_valid_o), 32'd0);
        @(posedge pclk); #1;

        // Reset during CALC, then a fresh CRC-8 run
        set_cfg(32'h0000_0007, 5'd7, 32'h0, 32'h0, 1'b0, 1'b0);
        do_clr();
        push_word(32'h3433_3231, 2'd3, 1'b0, 32'h0);
        push_word(32'h3837_3635, 2'd3, 1'b0, 32'h0);
        preset = 1'b1;
        @(negedge pclk);
        check("prst_res_valid", 32'(res_valid_o), 32'd0);
        check("prst_res_data",  res_data_o,       32'd0);
        check("prst_s_ready",   32'(s_ready_o),   32'd1);
        check("prst_busy",      32'(busy_o),      32'd0);
        check("prst_fifo_cnt",  32'(fifo_cnt_o),  32'd0);
        @(posedge pclk); #1;
        preset = 1'b0;
        @(posedge pclk); #1;
        do_clr();
        run_msg(32'h0000_00F4);
        drain();

        check("sb_empty_end", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
